// File: rtl/dual_issue_queue.sv
// dual_issue_queue
//   Buffers decoded instruction pairs in a circular FIFO and issues them
//   to an even pipe and an odd pipe. The head pair may issue both
//   instructions in one cycle if they target different pipes and b does
//   not read the register a writes. Otherwise a issues first and b
//   follows from the SECOND state.
//
// Handshake: every port transfers on a rising edge where valid && ready.
//   Each valid is produced from registered state and never depends on its
//   own ready. The one exception is b in the PAIR state. Its valid is also
//   gated by the ready of a's port. This keeps b from transferring in a
//   cycle where a does not, so the two pipes always see program order.
//
// Ports:
//   clk, reset (sync, active-low), flush
//   in_valid/in_ready plus in_* pair fields   push side, from the decoder
//   even_valid/even_ready/even_instr          even-pipe issue port
//   odd_valid/odd_ready/odd_instr             odd-pipe issue port
//   count                                     occupied entries, head included
//   dual_cnt, single_cnt                      only when ISSUE_STATS_EN is defined
//
// Optional feature macro: ISSUE_STATS_EN (issue statistics counters).
// Debug: the head FSM is held in `state` (state_t) for bound checkers.
module dual_issue_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int RW    = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IW-1:0]                in_instr_a,
  input  logic [IW-1:0]                in_instr_b,
  input  logic                         in_pipe_a,
  input  logic                         in_pipe_b,
  input  logic                         in_b_valid,
  input  logic                         in_wr_a,
  input  logic [RW-1:0]                in_rt_a,
  input  logic [3*RW-1:0]              in_src_b,
  input  logic [2:0]                   in_src_vld_b,
  output logic                         even_valid,
  input  logic                         even_ready,
  output logic [IW-1:0]                even_instr,
  output logic                         odd_valid,
  input  logic                         odd_ready,
  output logic [IW-1:0]                odd_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]                  dual_cnt,
  output logic [15:0]                  single_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PAIR   = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW-1:0] instr_a;
    logic [IW-1:0] instr_b;
    logic          pipe_a;
    logic          pipe_b;
    logic          b_valid;
    logic          dep;
  } entry_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  entry_t        head;
  entry_t        in_entry;
  logic          in_dep;
  logic          push;
  logic          pop;
  logic          a_ready;
  logic          b_ready;
  logic          b_dual;
  logic          a_xfer;
  logic          b_xfer;
  logic          even_xfer;
  logic          odd_xfer;
  logic [CW-1:0] count_next;

  // Hazard check: b reads (through any used source) the register a writes.
  // The src_b fields are packed ra at [RW-1:0], rb above it, rc on top.
  always_comb begin
    in_dep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (in_src_vld_b[i] && (in_src_b[i*RW +: RW] == in_rt_a)) in_dep = 1'b1;
    end
    in_dep = in_dep && in_wr_a;
  end

  always_comb begin
    in_entry.instr_a = in_instr_a;
    in_entry.instr_b = in_instr_b;
    in_entry.pipe_a  = in_pipe_a;
    in_entry.pipe_b  = in_pipe_b;
    in_entry.b_valid = in_b_valid;
    in_entry.dep     = in_dep;
  end

  // A full queue refuses a push even if the head pops in the same cycle.
  assign in_ready = reset && !flush && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  assign head    = mem[rd_ptr];
  assign a_ready = head.pipe_a ? odd_ready : even_ready;
  assign b_ready = head.pipe_b ? odd_ready : even_ready;
  assign b_dual  = head.b_valid && (head.pipe_b != head.pipe_a) && !head.dep;

  // Issue port drive. While reset is low nothing is presented, so no
  // partial transfer can happen around a mid-issue reset.
  always_comb begin
    even_valid = 1'b0;
    even_instr = '0;
    odd_valid  = 1'b0;
    odd_instr  = '0;
    if (reset) begin
      case (state)
        S_PAIR: begin
          if (head.pipe_a) begin
            odd_valid = 1'b1;
            odd_instr = head.instr_a;
          end else begin
            even_valid = 1'b1;
            even_instr = head.instr_a;
          end
          if (b_dual && a_ready) begin
            if (head.pipe_b) begin
              odd_valid = 1'b1;
              odd_instr = head.instr_b;
            end else begin
              even_valid = 1'b1;
              even_instr = head.instr_b;
            end
          end
        end
        S_SECOND: begin
          if (head.pipe_b) begin
            odd_valid = 1'b1;
            odd_instr = head.instr_b;
          end else begin
            even_valid = 1'b1;
            even_instr = head.instr_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign even_xfer = even_valid && even_ready;
  assign odd_xfer  = odd_valid && odd_ready;

  assign a_xfer = reset && (state == S_PAIR) && a_ready;
  assign b_xfer = reset && (((state == S_PAIR) && b_dual && a_ready && b_ready) ||
                            ((state == S_SECOND) && b_ready));

  // The entry leaves once its last instruction has gone.
  assign pop = ((state == S_PAIR) && a_xfer && (b_xfer || !head.b_valid)) ||
               ((state == S_SECOND) && b_xfer);

  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state  <= S_EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // A fresh head (after a pop or into an empty queue) always starts in
      // PAIR; a pair pushed this cycle becomes visible next cycle.
      if (pop || (state == S_EMPTY)) begin
        state <= (count_next != '0) ? S_PAIR : S_EMPTY;
      end else if ((state == S_PAIR) && a_xfer) begin
        state <= S_SECOND;
      end
    end
  end

  // Payload storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

`ifdef ISSUE_STATS_EN
  // Statistics survive flush and clear only on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
    end else begin
      if (even_xfer && odd_xfer && (dual_cnt != 16'hFFFF))
        dual_cnt <= dual_cnt + 16'd1;
      if ((even_xfer ^ odd_xfer) && (single_cnt != 16'hFFFF))
        single_cnt <= single_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// Bench for dual_issue_queue. The reference model keeps the buffered
// instructions as one program-ordered queue. From the queue head it
// derives what each issue port must show. It also derives count,
// in_ready and the optional statistics.
module tb_dual_issue_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int RW    = 7;
  localparam int CW    = $clog2(DEPTH+1);
  // element layout: {last, dual_ok, is_b, pipe, instr}
  localparam int EW    = IW + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_instr_a;
  logic [IW-1:0]     in_instr_b;
  logic              in_pipe_a;
  logic              in_pipe_b;
  logic              in_b_valid;
  logic              in_wr_a;
  logic [RW-1:0]     in_rt_a;
  logic [3*RW-1:0]   in_src_b;
  logic [2:0]        in_src_vld_b;
  logic              even_valid;
  logic              even_ready;
  logic [IW-1:0]     even_instr;
  logic              odd_valid;
  logic              odd_ready;
  logic [IW-1:0]     odd_instr;
  logic [CW-1:0]     count;
`ifdef ISSUE_STATS_EN
  logic [15:0]       dual_cnt;
  logic [15:0]       single_cnt;
`endif

  dual_issue_queue #(.DEPTH(DEPTH), .IW(IW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr_a(in_instr_a), .in_instr_b(in_instr_b),
    .in_pipe_a(in_pipe_a), .in_pipe_b(in_pipe_b), .in_b_valid(in_b_valid),
    .in_wr_a(in_wr_a), .in_rt_a(in_rt_a),
    .in_src_b(in_src_b), .in_src_vld_b(in_src_vld_b),
    .even_valid(even_valid), .even_ready(even_ready), .even_instr(even_instr),
    .odd_valid(odd_valid), .odd_ready(odd_ready), .odd_instr(odd_instr),
    .count(count)
`ifdef ISSUE_STATS_EN
    , .dual_cnt(dual_cnt), .single_cnt(single_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            model_count = 0;
  int            model_dual  = 0;
  int            model_single = 0;

  // Compute the hazard the way the rule reads: a writes rt and b uses it.
  function automatic bit calc_dep(input logic wr, input logic [RW-1:0] rt,
                                  input logic [3*RW-1:0] src, input logic [2:0] vld);
    logic [RW-1:0] r;
    calc_dep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = src[i*RW +: RW];
      if (wr && vld[i] && (r == rt)) calc_dep = 1'b1;
    end
  endfunction

  // Monitor: samples at the falling edge, which shows what will happen
  // at the next rising edge.
  logic [EW-1:0] h0, h1;
  bit            p0, p1;
  bit            rdy [2];
  bit            exp_v [2];
  logic [IW-1:0] exp_i [2];
  int            n_take;
  bit            exp_rdy;
  logic [EW-1:0] ea, eb;
  bit            dual_ok;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      exp_i[0] = '0;   exp_i[1] = '0;
      n_take   = 0;
      rdy[0]   = even_ready;
      rdy[1]   = odd_ready;
      if (reset && exp_q.size() > 0) begin
        h0 = exp_q[0];
        p0 = h0[IW];
        exp_v[p0] = 1'b1;
        exp_i[p0] = h0[IW-1:0];
        if (rdy[p0]) begin
          n_take = 1;
          // b may go with a only if it is dual-eligible and a goes too
          if (!h0[IW+1] && exp_q.size() > 1) begin
            h1 = exp_q[1];
            if (h1[IW+1] && h1[IW+2]) begin
              p1 = h1[IW];
              exp_v[p1] = 1'b1;
              exp_i[p1] = h1[IW-1:0];
              if (rdy[p1]) n_take = 2;
            end
          end
        end
      end
      exp_rdy = reset && !flush && (model_count < DEPTH);

      check("count",      64'(count),      64'(model_count));
      check("in_ready",   64'(in_ready),   64'(exp_rdy));
      check("even_valid", 64'(even_valid), 64'(exp_v[0]));
      check("even_instr", 64'(even_instr), 64'(exp_i[0]));
      check("odd_valid",  64'(odd_valid),  64'(exp_v[1]));
      check("odd_instr",  64'(odd_instr),  64'(exp_i[1]));
`ifdef ISSUE_STATS_EN
      check("dual_cnt",   64'(dual_cnt),   64'(model_dual));
      check("single_cnt", 64'(single_cnt), 64'(model_single));
`endif

      if (!reset) begin
        exp_q.delete();
        model_count  = 0;
        model_dual   = 0;
        model_single = 0;
      end else begin
        for (int k = 0; k < n_take; k++) begin
          h0 = exp_q.pop_front();
          if (h0[IW+3]) model_count--;
        end
        if (n_take == 2 && model_dual < 16'hFFFF) model_dual++;
        if (n_take == 1 && model_single < 16'hFFFF) model_single++;
        if (flush) begin
          exp_q.delete();
          model_count = 0;
        end else if (in_valid && exp_rdy) begin
          dual_ok = in_b_valid && (in_pipe_a != in_pipe_b) &&
                    !calc_dep(in_wr_a, in_rt_a, in_src_b, in_src_vld_b);
          ea = {~in_b_valid, 1'b0, 1'b0, in_pipe_a, in_instr_a};
          exp_q.push_back(ea);
          if (in_b_valid) begin
            eb = {1'b1, dual_ok, 1'b1, in_pipe_b, in_instr_b};
            exp_q.push_back(eb);
          end
          model_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [IW-1:0] a, input logic [IW-1:0] b,
                            input logic pa, input logic pb, input logic bv,
                            input logic wr, input logic [RW-1:0] rt,
                            input logic [3*RW-1:0] src, input logic [2:0] vld);
    in_valid     = 1'b1;
    in_instr_a   = a;
    in_instr_b   = b;
    in_pipe_a    = pa;
    in_pipe_b    = pb;
    in_b_valid   = bv;
    in_wr_a      = wr;
    in_rt_a      = rt;
    in_src_b     = src;
    in_src_vld_b = vld;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr_a = '0; in_instr_b = '0; in_pipe_a = 1'b0; in_pipe_b = 1'b0;
    in_b_valid = 1'b0; in_wr_a = 1'b0; in_rt_a = '0; in_src_b = '0;
    in_src_vld_b = '0; even_ready = 1'b0; odd_ready = 1'b0;

    cyc();
    mon_en = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // dual issue of an independent even/odd pair
    even_ready = 1'b1; odd_ready = 1'b1;
    drive_pair(32'hA000_0001, 32'hB000_0001, 1'b0, 1'b1, 1'b1, 1'b1, 7'd5,
               {7'd3, 7'd2, 7'd1}, 3'b111);
    cyc(); idle();
    repeat (3) cyc();

    // same-pipe pair drains in two cycles
    drive_pair(32'hA000_0002, 32'hB000_0002, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0,
               '0, 3'b000);
    cyc(); idle();
    repeat (4) cyc();

    // b reads r5 which a writes: a alone, then b
    drive_pair(32'hA000_0003, 32'hB000_0003, 1'b0, 1'b1, 1'b1, 1'b1, 7'd5,
               {7'd9, 7'd8, 7'd5}, 3'b001);
    cyc(); idle();
    repeat (4) cyc();

    // fill with the even pipe stalled; the extra pair is refused
    even_ready = 1'b0; odd_ready = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      drive_pair(32'hC000_0000 + i, 32'hD000_0000 + i, 1'b0, 1'b1, 1'b1, 1'b0,
                 7'd0, '0, 3'b000);
      cyc();
    end
    idle();
    repeat (2) cyc();
    even_ready = 1'b1;
    repeat (3 * DEPTH) cyc();

    // flush while in SECOND with three entries and a push offered
    even_ready = 1'b0; odd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'hE000_0000 + i, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b1, 1'b0,
                 7'd0, '0, 3'b000);
      cyc();
    end
    idle();
    cyc();
    even_ready = 1'b1;
    cyc();
    even_ready = 1'b0;
    flush = 1'b1;
    drive_pair(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, '0, 3'b000);
    cyc();
    flush = 1'b0; idle();
    repeat (3) cyc();

    // statistics: 3 dual pairs then 2 same-pipe pairs after a fresh reset
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    even_ready = 1'b1; odd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pair(32'h5000_0000 + i, 32'h6000_0000 + i, 1'b1, 1'b0, 1'b1, 1'b0,
                 7'd0, '0, 3'b000);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drive_pair(32'h7000_0000 + i, 32'h7100_0000 + i, 1'b1, 1'b1, 1'b1, 1'b0,
                 7'd0, '0, 3'b000);
      cyc();
    end
    idle();
    repeat (6) cyc();
`ifdef ISSUE_STATS_EN
    check("dual_cnt_final", 64'(dual_cnt), 64'd3);
    check("single_cnt_final", 64'(single_cnt), 64'd4);
`endif

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 2500; n++) begin
      even_ready = ($urandom_range(0, 3) != 0);
      odd_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) != 0)
        drive_pair($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   RW'($urandom_range(0, 3)),
                   {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))},
                   3'($urandom_range(0, 7)));
      else
        idle();
      cyc();
    end

    flush = 1'b0; reset = 1'b1; idle();
    even_ready = 1'b1; odd_ready = 1'b1;
    repeat (3 * DEPTH) cyc();
    check("drained_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
